// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter.
//  arb_state_t : arbiter FSM states (3-bit encoding)
//  owner_t     : who currently drives the memory port
//  sat_inc16   : saturating 16-bit increment used by the loader write counter
package mem_port_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_HOLD    = 3'd0,
        ARB_RUN     = 3'd1,
        ARB_DRAIN   = 3'd2,
        ARB_SERVICE = 3'd3,
        ARB_RESUME  = 3'd4
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_LOADER = 2'd1,
        OWN_CPU    = 2'd2
    } owner_t;

    localparam int LOAD_CNT_W = 16;

    function automatic logic [LOAD_CNT_W-1:0] sat_inc16(input logic [LOAD_CNT_W-1:0] v);
        return (v == {LOAD_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mem_port_mux.sv
// Combinational owner-select for the single memory port.
//  i_owner           : current port owner (NONE/LOADER/CPU)
//  i_cpu_addr/we/data: CPU side request
//  i_ld_addr/we/data : loader side request (i_ld_we already qualified by grant)
//  o_mem_addr/we/din : to memory; all zero when nobody owns the port
module mem_port_mux
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  owner_t                  i_owner,
    input  logic [ADDR_WIDTH-1:0]   i_cpu_addr,
    input  logic                    i_cpu_we,
    input  logic [DATA_WIDTH-1:0]   i_cpu_data,
    input  logic [ADDR_WIDTH-1:0]   i_ld_addr,
    input  logic                    i_ld_we,
    input  logic [DATA_WIDTH-1:0]   i_ld_data,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic                    o_mem_we,
    output logic [DATA_WIDTH-1:0]   o_mem_din
);

    always_comb begin
        o_mem_addr = '0;
        o_mem_we   = 1'b0;
        o_mem_din  = '0;
        case (i_owner)
            OWN_LOADER: begin
                o_mem_addr = i_ld_addr;
                o_mem_we   = i_ld_we;
                o_mem_din  = i_ld_data;
            end
            OWN_CPU: begin
                o_mem_addr = i_cpu_addr;
                o_mem_we   = i_cpu_we;
                o_mem_din  = i_cpu_data;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between an external loader and the CPU.
// Holds the CPU in reset while the loader fills memory, releases it on start,
// and halts it at an instruction boundary when the loader needs the port later.
//  i_clk, i_reset_n        : clock, async active-low reset
//  i_start                 : pulse, release CPU from HOLD
//  i_ld_req/we/addr/data   : loader request (level req)
//  o_ld_gnt/rvalid/rdata   : loader grant and read return (1-cycle latency)
//  i_cpu_addr/we/data      : CPU port request
//  i_instruction_done      : instruction-boundary pulse from decoder
//  o_cpu_reset_n/o_cpu_halt: CPU reset and fetch stall
//  o_mem_addr/we/din, i_mem_dout : memory port
//  o_owner                 : 0=NONE 1=LOADER 2=CPU
//  o_load_count            : granted loader writes, saturating
//  o_drain_timeout         : sticky, drain expired without instruction_done
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH    = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_start,
    input  logic                    i_ld_req,
    input  logic                    i_ld_we,
    input  logic [ADDR_WIDTH-1:0]   i_ld_addr,
    input  logic [DATA_WIDTH-1:0]   i_ld_data,
    output logic                    o_ld_gnt,
    output logic                    o_ld_rvalid,
    output logic [DATA_WIDTH-1:0]   o_ld_rdata,
    input  logic [ADDR_WIDTH-1:0]   i_cpu_addr,
    input  logic                    i_cpu_we,
    input  logic [DATA_WIDTH-1:0]   i_cpu_data,
    input  logic                    i_instruction_done,
    output logic                    o_cpu_reset_n,
    output logic                    o_cpu_halt,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic                    o_mem_we,
    output logic [DATA_WIDTH-1:0]   o_mem_din,
    input  logic [DATA_WIDTH-1:0]   i_mem_dout,
    output logic [1:0]              o_owner,
    output logic [LOAD_CNT_W-1:0]   o_load_count,
    output logic                    o_drain_timeout
);

    localparam int TW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;

    arb_state_t             r_state;
    arb_state_t             w_next;
    logic                   r_start_pend;
    logic                   w_start_pend_nxt;
    logic [TW-1:0]          r_timer;
    logic                   w_expired;
    logic                   w_set_timeout;
    logic                   r_drain_timeout;
    logic [LOAD_CNT_W-1:0]  r_load_count;
    logic                   r_ld_rvalid;

    owner_t                 w_owner_fsm;
    logic                   w_gnt_fsm;
    logic                   w_cpu_reset_n;
    logic                   w_cpu_halt;

    owner_t                 w_owner;
    logic                   w_ld_gnt;

    assign w_expired = (r_timer == TW'(DRAIN_TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= ARB_HOLD;
            r_start_pend <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_start_pend <= w_start_pend_nxt;
        end
    end

    always_comb begin
        w_next           = r_state;
        w_start_pend_nxt = r_start_pend;
        w_set_timeout    = 1'b0;
        w_owner_fsm      = OWN_NONE;
        w_gnt_fsm        = 1'b0;
        w_cpu_reset_n    = 1'b1;
        w_cpu_halt       = 1'b0;
        case (r_state)
            ARB_HOLD: begin
                w_cpu_reset_n = 1'b0;
                w_gnt_fsm     = i_ld_req;
                w_owner_fsm   = i_ld_req ? OWN_LOADER : OWN_NONE;
                // A start seen while the loader is busy is remembered and
                // honoured on the first cycle the loader lets go.
                if (i_start || r_start_pend) begin
                    if (!i_ld_req) begin
                        w_next           = ARB_RUN;
                        w_start_pend_nxt = 1'b0;
                    end else begin
                        w_start_pend_nxt = 1'b1;
                    end
                end
            end
            ARB_RUN: begin
                w_owner_fsm = OWN_CPU;
                if (i_ld_req) w_next = ARB_DRAIN;
            end
            ARB_DRAIN: begin
                // CPU keeps the port to finish its current instruction.
                w_owner_fsm = OWN_CPU;
                w_cpu_halt  = 1'b1;
                if (!i_ld_req) begin
                    w_next = ARB_RUN;
                end else if (i_instruction_done) begin
                    w_next = ARB_SERVICE;
                end else if (w_expired) begin
                    w_next        = ARB_SERVICE;
                    w_set_timeout = 1'b1;
                end
            end
            ARB_SERVICE: begin
                w_owner_fsm = OWN_LOADER;
                w_gnt_fsm   = i_ld_req;
                w_cpu_halt  = 1'b1;
                if (!i_ld_req) w_next = ARB_RESUME;
            end
            ARB_RESUME: begin
                w_cpu_halt = 1'b1;
                w_next     = ARB_RUN;
            end
            default: begin
                w_next = ARB_HOLD;
            end
        endcase
    end

    // During reset the state is already HOLD, but the loader must not be
    // granted off a still-asserted ld_req; gate grant and ownership directly.
    assign w_ld_gnt = w_gnt_fsm & i_reset_n;
    assign w_owner  = i_reset_n ? w_owner_fsm : OWN_NONE;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_timer <= '0;
        end else if (r_state == ARB_DRAIN) begin
            r_timer <= r_timer + TW'(1);
        end else begin
            r_timer <= '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_drain_timeout <= 1'b0;
            r_load_count    <= '0;
            r_ld_rvalid     <= 1'b0;
        end else begin
            if (w_set_timeout) r_drain_timeout <= 1'b1;
            if (w_ld_gnt && i_ld_we) r_load_count <= sat_inc16(r_load_count);
            r_ld_rvalid <= w_ld_gnt & ~i_ld_we;
        end
    end

    mem_port_mux #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mux (
        .i_owner    (w_owner),
        .i_cpu_addr (i_cpu_addr),
        .i_cpu_we   (i_cpu_we),
        .i_cpu_data (i_cpu_data),
        .i_ld_addr  (i_ld_addr),
        .i_ld_we    (i_ld_we & w_ld_gnt),
        .i_ld_data  (i_ld_data),
        .o_mem_addr (o_mem_addr),
        .o_mem_we   (o_mem_we),
        .o_mem_din  (o_mem_din)
    );

    assign o_ld_gnt        = w_ld_gnt;
    assign o_ld_rvalid     = r_ld_rvalid;
    assign o_ld_rdata      = i_mem_dout;
    assign o_cpu_reset_n   = w_cpu_reset_n;
    assign o_cpu_halt      = w_cpu_halt;
    assign o_owner         = w_owner;
    assign o_load_count    = r_load_count;
    assign o_drain_timeout = r_drain_timeout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        i_clk = 1'b0;
    logic        i_reset_n, i_start, i_ld_req, i_ld_we;
    logic [15:0] i_ld_addr;
    logic [7:0]  i_ld_data;
    logic        o_ld_gnt, o_ld_rvalid;
    logic [7:0]  o_ld_rdata;
    logic [15:0] i_cpu_addr;
    logic        i_cpu_we;
    logic [7:0]  i_cpu_data;
    logic        i_instruction_done;
    logic        o_cpu_reset_n, o_cpu_halt;
    logic [15:0] o_mem_addr;
    logic        o_mem_we;
    logic [7:0]  o_mem_din;
    logic [7:0]  i_mem_dout;
    logic [1:0]  o_owner;
    logic [15:0] o_load_count;
    logic        o_drain_timeout;

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    mem_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .DRAIN_TIMEOUT(64)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start),
        .i_ld_req(i_ld_req), .i_ld_we(i_ld_we), .i_ld_addr(i_ld_addr), .i_ld_data(i_ld_data),
        .o_ld_gnt(o_ld_gnt), .o_ld_rvalid(o_ld_rvalid), .o_ld_rdata(o_ld_rdata),
        .i_cpu_addr(i_cpu_addr), .i_cpu_we(i_cpu_we), .i_cpu_data(i_cpu_data),
        .i_instruction_done(i_instruction_done),
        .o_cpu_reset_n(o_cpu_reset_n), .o_cpu_halt(o_cpu_halt),
        .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_din(o_mem_din),
        .i_mem_dout(i_mem_dout), .o_owner(o_owner), .o_load_count(o_load_count),
        .o_drain_timeout(o_drain_timeout)
    );

    // Memory with one-cycle read latency, read-before-write.
    logic [7:0] tbmem [0:65535];
    always @(posedge i_clk) begin
        if (o_mem_we) tbmem[o_mem_addr] <= o_mem_din;
        i_mem_dout <= tbmem[o_mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Inputs are driven 1 time unit after the rising edge, outputs sampled 2 later.
    task automatic nxt();
        @(posedge i_clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    typedef struct {
        logic        req, we;
        logic [15:0] addr;
        logic [7:0]  data;
        logic        e_gnt, e_rst_n, e_rv;
        logic [15:0] e_cnt;
        logic [7:0]  e_rd;
    } vec_t;
    vec_t vt [33];

    // Reference model state for the randomized phase.
    localparam int P_HOLD = 0, P_RUN = 1, P_DRAIN = 2, P_SERV = 3, P_RESUME = 4;
    int          m_ph, m_drain_cyc;
    bit          m_pend, m_to, m_rv, m_rv_known;
    logic [15:0] m_cnt;
    logic [7:0]  m_rd;
    logic [7:0]  m_mem [16];
    bit          m_known [16];

    initial begin
        logic        e_gnt, e_we, e_halt, e_rst;
        logic [1:0]  e_own;
        logic [15:0] e_addr;
        logic [7:0]  e_din;
        bit          done_en;

        i_reset_n = 1'b0; i_start = 1'b0; i_ld_req = 1'b1; i_ld_we = 1'b1;
        i_ld_addr = 16'h5; i_ld_data = 8'h55; i_cpu_addr = 16'h0; i_cpu_we = 1'b1;
        i_cpu_data = 8'h0; i_instruction_done = 1'b0;
        #3;
        // reset: loader request ignored, everything quiet
        chk("rst_gnt", 32'(o_ld_gnt), 0);
        chk("rst_mem_we", 32'(o_mem_we), 0);
        chk("rst_cpu_reset_n", 32'(o_cpu_reset_n), 0);
        chk("rst_halt", 32'(o_cpu_halt), 0);
        chk("rst_owner", 32'(o_owner), 0);
        chk("rst_cnt", 32'(o_load_count), 0);
        chk("rst_rvalid", 32'(o_ld_rvalid), 0);
        chk("rst_timeout", 32'(o_drain_timeout), 0);
        i_cpu_we = 1'b0;
        nxt();
        i_reset_n = 1'b1;

        // ---- test 1: loader fill and readback in HOLD (table driven)
        for (int i = 0; i < 16; i++)
            vt[i] = '{1'b1, 1'b1, 16'(i), 8'(i), 1'b1, 1'b0, 1'b0, 16'(i), 8'h0};
        for (int j = 0; j < 16; j++)
            vt[16+j] = '{1'b1, 1'b0, 16'(j), 8'h0, 1'b1, 1'b0, (j > 0), 16'd16, 8'(j-1)};
        vt[32] = '{1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b1, 16'd16, 8'd15};
        for (int i = 0; i < 33; i++) begin
            i_ld_req = vt[i].req; i_ld_we = vt[i].we;
            i_ld_addr = vt[i].addr; i_ld_data = vt[i].data;
            settle();
            chk("t1_gnt", 32'(o_ld_gnt), 32'(vt[i].e_gnt));
            chk("t1_cpu_reset_n", 32'(o_cpu_reset_n), 32'(vt[i].e_rst_n));
            chk("t1_cnt", 32'(o_load_count), 32'(vt[i].e_cnt));
            chk("t1_rvalid", 32'(o_ld_rvalid), 32'(vt[i].e_rv));
            if (vt[i].e_rv) chk("t1_rdata", 32'(o_ld_rdata), 32'(vt[i].e_rd));
            if (vt[i].we) chk("t1_mem_we", 32'(o_mem_we), 1);
            nxt();
        end

        // ---- test 2: start while loader busy, RUN on cycle after drop
        i_ld_req = 1'b1; i_ld_we = 1'b0; i_start = 1'b1;
        settle(); chk("t2_hold0", 32'(o_cpu_reset_n), 0); nxt();
        i_start = 1'b0;
        settle(); chk("t2_hold1", 32'(o_cpu_reset_n), 0); nxt();
        settle(); chk("t2_hold2", 32'(o_cpu_reset_n), 0); nxt();
        i_ld_req = 1'b0;
        settle(); chk("t2_dropcyc", 32'(o_cpu_reset_n), 0); nxt();
        i_cpu_addr = 16'h1234;
        settle();
        chk("t2_run_rst", 32'(o_cpu_reset_n), 1);
        chk("t2_run_owner", 32'(o_owner), 2);
        chk("t2_addr_a", 32'(o_mem_addr), 32'h1234);
        nxt();
        i_cpu_addr = 16'h0042;
        settle(); chk("t2_addr_b", 32'(o_mem_addr), 32'h0042); nxt();

        // ---- test 3: drain ended by instruction_done
        i_ld_req = 1'b1;
        settle(); chk("t3_halt_c0", 32'(o_cpu_halt), 0); nxt();
        for (int k = 1; k <= 5; k++) begin
            i_instruction_done = (k == 5);
            settle();
            chk("t3_drain_halt", 32'(o_cpu_halt), 1);
            chk("t3_drain_gnt", 32'(o_ld_gnt), 0);
            nxt();
        end
        i_instruction_done = 1'b0; i_cpu_we = 1'b1; i_cpu_addr = 16'h5;
        settle();
        chk("t3_svc_gnt", 32'(o_ld_gnt), 1);
        chk("t3_svc_owner", 32'(o_owner), 1);
        chk("t3_svc_cpu_we_blocked", 32'(o_mem_we), 0);
        nxt();
        i_ld_req = 1'b0;
        settle(); chk("t3_svc_last_gnt", 32'(o_ld_gnt), 0); nxt();
        settle(); chk("t3_resume_owner", 32'(o_owner), 0); chk("t3_resume_we", 32'(o_mem_we), 0); nxt();
        settle(); chk("t3_run_halt", 32'(o_cpu_halt), 0); chk("t3_run_we", 32'(o_mem_we), 1); nxt();
        i_cpu_we = 1'b0;

        // ---- ld_req withdrawn during DRAIN: back to RUN, no grant
        i_ld_req = 1'b1; nxt();
        i_ld_req = 1'b0;
        settle(); chk("wd_gnt", 32'(o_ld_gnt), 0); chk("wd_halt", 32'(o_cpu_halt), 1); nxt();
        settle(); chk("wd_run_halt", 32'(o_cpu_halt), 0); chk("wd_run_owner", 32'(o_owner), 2); nxt();

        // ---- test 4: drain timeout
        i_ld_req = 1'b1; nxt();
        for (int k = 1; k <= 64; k++) begin
            if (k == 64) begin
                settle();
                chk("t4_last_drain_gnt", 32'(o_ld_gnt), 0);
                chk("t4_last_drain_to", 32'(o_drain_timeout), 0);
            end
            nxt();
        end
        i_ld_we = 1'b1; i_ld_addr = 16'h3; i_ld_data = 8'hAA;
        settle();
        chk("t4_svc_gnt", 32'(o_ld_gnt), 1);
        chk("t4_svc_owner", 32'(o_owner), 1);
        chk("t4_timeout", 32'(o_drain_timeout), 1);
        chk("t4_svc_we", 32'(o_mem_we), 1);
        nxt();
        i_ld_req = 1'b0;
        settle(); chk("t4_drop_we", 32'(o_mem_we), 0); nxt();
        i_cpu_we = 1'b1; i_cpu_addr = 16'h7;
        settle();
        chk("t4_resume_we", 32'(o_mem_we), 0);
        chk("t4_resume_owner", 32'(o_owner), 0);
        chk("t4_resume_halt", 32'(o_cpu_halt), 1);
        nxt();
        settle();
        chk("t4_run_halt", 32'(o_cpu_halt), 0);
        chk("t4_run_we", 32'(o_mem_we), 1);
        chk("t4_timeout_sticky", 32'(o_drain_timeout), 1);
        nxt();
        i_cpu_we = 1'b0; i_ld_we = 1'b0;

        // ---- test 5: async reset mid-SERVICE
        i_ld_req = 1'b1; nxt();
        i_instruction_done = 1'b1; nxt();
        i_instruction_done = 1'b0; i_ld_we = 1'b1; i_ld_addr = 16'h9;
        settle();
        chk("t5_pre_we", 32'(o_mem_we), 1);
        chk("t5_pre_cnt", 32'(o_load_count), 17);
        #1 i_reset_n = 1'b0;
        #1;
        chk("t5_we", 32'(o_mem_we), 0);
        chk("t5_gnt", 32'(o_ld_gnt), 0);
        chk("t5_cpu_reset_n", 32'(o_cpu_reset_n), 0);
        chk("t5_cnt", 32'(o_load_count), 0);
        chk("t5_owner", 32'(o_owner), 0);
        chk("t5_timeout", 32'(o_drain_timeout), 0);
        nxt(); nxt();
        i_reset_n = 1'b1;

        // ---- test 6: counter saturation (loader writes in HOLD)
        for (int i = 0; i < 70000; i++) begin
            i_ld_addr = 16'(i);
            if (i == 65534) begin settle(); chk("t6_cnt_fffe", 32'(o_load_count), 32'hFFFE); end
            if (i == 65535) begin settle(); chk("t6_cnt_ffff", 32'(o_load_count), 32'hFFFF); end
            nxt();
        end
        settle();
        chk("t6_cnt_sat", 32'(o_load_count), 32'hFFFF);
        chk("t6_gnt", 32'(o_ld_gnt), 1);
        nxt();

        // ---- randomized run against reference model
        i_reset_n = 1'b0; i_ld_req = 1'b0; i_ld_we = 1'b0; i_start = 1'b0;
        nxt();
        i_reset_n = 1'b1;
        m_ph = P_HOLD; m_pend = 0; m_to = 0; m_rv = 0; m_rv_known = 0;
        m_cnt = 16'h0; m_rd = 8'h0; m_drain_cyc = 0; done_en = 1;
        for (int a = 0; a < 16; a++) begin m_known[a] = 0; m_mem[a] = 8'h0; end
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) done_en = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 7) == 0) i_ld_req = ~i_ld_req;
            i_ld_we = 1'($urandom_range(0, 1));
            i_ld_addr = 16'($urandom_range(0, 15));
            i_ld_data = 8'($urandom);
            i_cpu_addr = 16'($urandom_range(0, 15));
            i_cpu_we = ($urandom_range(0, 3) == 0);
            i_cpu_data = 8'($urandom);
            i_instruction_done = done_en && ($urandom_range(0, 5) == 0);
            i_start = ($urandom_range(0, 19) == 0);

            e_gnt = i_ld_req && (m_ph == P_HOLD || m_ph == P_SERV);
            if (m_ph == P_HOLD)                        e_own = i_ld_req ? 2'd1 : 2'd0;
            else if (m_ph == P_RUN || m_ph == P_DRAIN) e_own = 2'd2;
            else if (m_ph == P_SERV)                   e_own = 2'd1;
            else                                       e_own = 2'd0;
            if (e_own == 2'd1)      begin e_addr = i_ld_addr;  e_din = i_ld_data;  e_we = i_ld_we && e_gnt; end
            else if (e_own == 2'd2) begin e_addr = i_cpu_addr; e_din = i_cpu_data; e_we = i_cpu_we; end
            else                    begin e_addr = 16'h0;      e_din = 8'h0;       e_we = 1'b0; end
            e_rst  = (m_ph != P_HOLD);
            e_halt = (m_ph == P_DRAIN || m_ph == P_SERV || m_ph == P_RESUME);

            settle();
            chk("r_gnt", 32'(o_ld_gnt), 32'(e_gnt));
            chk("r_owner", 32'(o_owner), 32'(e_own));
            chk("r_mem_we", 32'(o_mem_we), 32'(e_we));
            chk("r_mem_addr", 32'(o_mem_addr), 32'(e_addr));
            chk("r_mem_din", 32'(o_mem_din), 32'(e_din));
            chk("r_cpu_reset_n", 32'(o_cpu_reset_n), 32'(e_rst));
            chk("r_halt", 32'(o_cpu_halt), 32'(e_halt));
            chk("r_cnt", 32'(o_load_count), 32'(m_cnt));
            chk("r_timeout", 32'(o_drain_timeout), 32'(m_to));
            chk("r_rvalid", 32'(o_ld_rvalid), 32'(m_rv));
            if (m_rv && m_rv_known) chk("r_rdata", 32'(o_ld_rdata), 32'(m_rd));

            // advance the model by one clock
            m_rv_known = m_known[e_addr[3:0]];
            m_rd = m_mem[e_addr[3:0]];
            if (e_we) begin m_mem[e_addr[3:0]] = e_din; m_known[e_addr[3:0]] = 1; end
            m_rv = e_gnt && !i_ld_we;
            if (e_gnt && i_ld_we && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            case (m_ph)
                P_HOLD: if (i_start || m_pend) begin
                    if (!i_ld_req) begin m_ph = P_RUN; m_pend = 0; end
                    else m_pend = 1;
                end
                P_RUN: if (i_ld_req) begin m_ph = P_DRAIN; m_drain_cyc = 0; end
                P_DRAIN: begin
                    if (!i_ld_req) m_ph = P_RUN;
                    else if (i_instruction_done) m_ph = P_SERV;
                    else if (m_drain_cyc == 63) begin m_ph = P_SERV; m_to = 1; end
                    m_drain_cyc++;
                end
                P_SERV: if (!i_ld_req) m_ph = P_RESUME;
                default: m_ph = P_RUN;
            endcase
            nxt();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
